uart_cmd_ctrl: RTL and testbench

Command sequencer between the UART receive path and the register-file/ALU datapath. It consumes validated bytes from the UART RX top, decodes multi-byte command frames, and issues register-file writes and reads, operand loads and ALU operations. It pushes result bytes toward the TX FIFO and drives the ALU clock-gate enable, so the ALU clock runs only while an ALU command is in flight.

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, FSM encoding
// and the fixed register-file slots used for ALU operands.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OP_A,
    S_OP_B,
    S_FUN,
    S_ALU_WAIT,
    S_TX_LO,
    S_TX_HI
  } state_t;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Frame decoder between the UART RX path and the register-file/ALU datapath;
// issues RF/ALU strobes, gates the ALU clock and pushes result bytes to TX.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_W-1:0]     RF_Address,
  output logic [DATA_W-1:0]     RF_WrData,
  input  logic [DATA_W-1:0]     RF_RdData,
  input  logic                  RF_RdData_VLD,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  input  logic [2*DATA_W-1:0]   ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic                  CLK_GATE_EN,
  output logic [DATA_W-1:0]     TX_DATA,
  output logic                  TX_VLD,
  input  logic                  TX_FULL
);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_is_alu;
  logic                  r_rf_wren;
  logic                  r_rf_rden;
  logic [ADDR_W-1:0]     r_rf_addr;
  logic [DATA_W-1:0]     r_rf_wrdata;
  logic                  r_alu_en;
  logic [3:0]            r_alu_fun;
  logic                  r_gate;
  logic [DATA_W-1:0]     r_tx_data;
  logic                  r_tx_vld;

  state_t                w_state_next;
  logic [ADDR_W-1:0]     w_addr_next;
  logic [2*DATA_W-1:0]   w_result_next;
  logic                  w_is_alu_next;
  logic                  w_rf_wren_next;
  logic                  w_rf_rden_next;
  logic [ADDR_W-1:0]     w_rf_addr_next;
  logic [DATA_W-1:0]     w_rf_wrdata_next;
  logic                  w_alu_en_next;
  logic [3:0]            w_alu_fun_next;
  logic                  w_gate_next;
  logic [DATA_W-1:0]     w_tx_data_next;
  logic                  w_tx_vld_next;
  logic                  w_byte;

  // An errored frame never counts as a byte, even when flagged valid.
  assign w_byte = RX_D_VLD && !RX_ERR;

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_result_next    = r_result;
    w_is_alu_next    = r_is_alu;
    w_rf_wren_next   = 1'b0;
    w_rf_rden_next   = 1'b0;
    w_rf_addr_next   = r_rf_addr;
    w_rf_wrdata_next = r_rf_wrdata;
    w_alu_en_next    = 1'b0;
    w_alu_fun_next   = r_alu_fun;
    w_gate_next      = r_gate;
    w_tx_data_next   = r_tx_data;
    w_tx_vld_next    = 1'b0;

    if (RX_ERR) begin
      w_state_next  = S_IDLE;
      w_addr_next   = '0;
      w_result_next = '0;
      w_is_alu_next = 1'b0;
      w_gate_next   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_byte) begin
            if (RX_P_DATA == DATA_W'(CMD_RF_WR)) begin
              w_state_next = S_WR_ADDR;
            end else if (RX_P_DATA == DATA_W'(CMD_RF_RD)) begin
              w_state_next = S_RD_ADDR;
            end else if (RX_P_DATA == DATA_W'(CMD_ALU_OP)) begin
              w_state_next = S_OP_A;
            end else if (RX_P_DATA == DATA_W'(CMD_ALU_NOP)) begin
              w_state_next = S_FUN;
              w_gate_next  = 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (w_byte) begin
            w_addr_next  = RX_P_DATA[ADDR_W-1:0];
            w_state_next = S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (w_byte) begin
            w_rf_wren_next   = 1'b1;
            w_rf_addr_next   = r_addr;
            w_rf_wrdata_next = RX_P_DATA;
            w_addr_next      = '0;
            w_state_next     = S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (w_byte) begin
            w_rf_rden_next = 1'b1;
            w_rf_addr_next = RX_P_DATA[ADDR_W-1:0];
            w_state_next   = S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (RF_RdData_VLD) begin
            w_result_next = {{DATA_W{1'b0}}, RF_RdData};
            w_is_alu_next = 1'b0;
            w_state_next  = S_TX_LO;
          end
        end
        S_OP_A: begin
          if (w_byte) begin
            w_rf_wren_next   = 1'b1;
            w_rf_addr_next   = ADDR_W'(OPA_ADDR);
            w_rf_wrdata_next = RX_P_DATA;
            w_state_next     = S_OP_B;
          end
        end
        S_OP_B: begin
          if (w_byte) begin
            w_rf_wren_next   = 1'b1;
            w_rf_addr_next   = ADDR_W'(OPB_ADDR);
            w_rf_wrdata_next = RX_P_DATA;
            w_state_next     = S_FUN;
            w_gate_next      = 1'b1;
          end
        end
        S_FUN: begin
          // The gate rose on entry here, so ALU_EN always trails it by a cycle or more.
          if (w_byte) begin
            w_alu_en_next  = 1'b1;
            w_alu_fun_next = RX_P_DATA[3:0];
            w_state_next   = S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            w_result_next = ALU_OUT;
            w_is_alu_next = 1'b1;
            w_gate_next   = 1'b0;
            w_state_next  = S_TX_LO;
          end
        end
        S_TX_LO: begin
          if (!TX_FULL) begin
            w_tx_vld_next  = 1'b1;
            w_tx_data_next = r_result[DATA_W-1:0];
            w_state_next   = r_is_alu ? S_TX_HI : S_IDLE;
          end
        end
        S_TX_HI: begin
          if (!TX_FULL) begin
            w_tx_vld_next  = 1'b1;
            w_tx_data_next = r_result[2*DATA_W-1:DATA_W];
            w_state_next   = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_result    <= '0;
      r_is_alu    <= 1'b0;
      r_rf_wren   <= 1'b0;
      r_rf_rden   <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_wrdata <= '0;
      r_alu_en    <= 1'b0;
      r_alu_fun   <= '0;
      r_gate      <= 1'b0;
      r_tx_data   <= '0;
      r_tx_vld    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_result    <= w_result_next;
      r_is_alu    <= w_is_alu_next;
      r_rf_wren   <= w_rf_wren_next;
      r_rf_rden   <= w_rf_rden_next;
      r_rf_addr   <= w_rf_addr_next;
      r_rf_wrdata <= w_rf_wrdata_next;
      r_alu_en    <= w_alu_en_next;
      r_alu_fun   <= w_alu_fun_next;
      r_gate      <= w_gate_next;
      r_tx_data   <= w_tx_data_next;
      r_tx_vld    <= w_tx_vld_next;
    end
  end

  assign RF_WrEn     = r_rf_wren;
  assign RF_RdEn     = r_rf_rden;
  assign RF_Address  = r_rf_addr;
  assign RF_WrData   = r_rf_wrdata;
  assign ALU_EN      = r_alu_en;
  assign ALU_FUN     = r_alu_fun;
  assign CLK_GATE_EN = r_gate;
  assign TX_DATA     = r_tx_data;
  assign TX_VLD      = r_tx_vld;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: drives command frames byte by byte and
// checks strobes, responses and abort behaviour against hand-derived values.
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        RX_ERR = 1'b0;
  logic        RF_WrEn, RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData = '0;
  logic        RF_RdData_VLD = 1'b0;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_DATA;
  logic        TX_VLD;
  logic        TX_FULL = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  tx_log[$];
  logic [11:0] wr_log[$];
  int          rd_cnt = 0;
  int          alu_cnt = 0;
  int          bad_gate = 0;
  logic        prev_gate = 1'b0;

  uart_cmd_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_FULL(TX_FULL)
  );

  always #5 CLK = ~CLK;

  // Transaction log, sampled just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (RF_WrEn) begin
      wr_log.push_back({RF_Address, RF_WrData});
      $display("[%0t] rf write addr=%0d data=%02h", $time, RF_Address, RF_WrData);
    end
    if (RF_RdEn) begin
      rd_cnt++;
      $display("[%0t] rf read  addr=%0d", $time, RF_Address);
    end
    if (ALU_EN) begin
      alu_cnt++;
      if (!prev_gate || !CLK_GATE_EN) bad_gate++;
      $display("[%0t] alu op   fun=%0d", $time, ALU_FUN);
    end
    if (TX_VLD) begin
      tx_log.push_back(TX_DATA);
      $display("[%0t] tx push  data=%02h", $time, TX_DATA);
    end
    prev_gate = CLK_GATE_EN;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    wr_log.delete();
    rd_cnt = 0;
    alu_cnt = 0;
    bad_gate = 0;
  endtask

  // Returns on the falling edge after the byte was sampled, so strobes it caused are visible.
  task automatic send_byte(input logic [7:0] b, input logic err);
    idle(2);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    RX_ERR    = err;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    RX_ERR    = 1'b0;
  endtask

  task automatic send_err();
    idle(2);
    RX_ERR = 1'b1;
    @(negedge CLK);
    RX_ERR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(3);
    n_checks++;
    if ({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_VLD} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, want 00000", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_VLD});
    end
    n_checks++;
    if ({RF_Address, RF_WrData, ALU_FUN, TX_DATA} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, want 000000", {RF_Address, RF_WrData, ALU_FUN, TX_DATA});
    end
    RST = 1'b0;
    idle(2);
  endtask

  task automatic test_reg_write();
    clear_logs();
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h3C, 1'b0);
    n_checks++;
    if (RF_WrEn !== 1'b1 || RF_Address !== 4'd5 || RF_WrData !== 8'h3C) begin
      n_fail++;
      $display("FAIL wr_strobe: got en=%b addr=%0d data=%02h, want en=1 addr=5 data=3c", RF_WrEn, RF_Address, RF_WrData);
    end
    idle(5);
    n_checks++;
    if (wr_log.size() != 1 || tx_log.size() != 0) begin
      n_fail++;
      $display("FAIL wr_count: got writes=%0d tx=%0d, want writes=1 tx=0", wr_log.size(), tx_log.size());
    end
  endtask

  task automatic test_reg_read();
    clear_logs();
    send_byte(8'hBB, 1'b0);
    send_byte(8'h05, 1'b0);
    n_checks++;
    if (RF_RdEn !== 1'b1 || RF_Address !== 4'd5) begin
      n_fail++;
      $display("FAIL rd_strobe: got en=%b addr=%0d, want en=1 addr=5", RF_RdEn, RF_Address);
    end
    idle(2);
    RF_RdData = 8'h3C;
    RF_RdData_VLD = 1'b1;
    @(negedge CLK);
    RF_RdData_VLD = 1'b0;
    RF_RdData = 8'h00;
    @(negedge CLK);
    n_checks++;
    if (TX_VLD !== 1'b1 || TX_DATA !== 8'h3C) begin
      n_fail++;
      $display("FAIL rd_tx: got vld=%b data=%02h, want vld=1 data=3c", TX_VLD, TX_DATA);
    end
    idle(5);
    n_checks++;
    if (tx_log.size() != 1 || rd_cnt != 1) begin
      n_fail++;
      $display("FAIL rd_count: got tx=%0d reads=%0d, want tx=1 reads=1", tx_log.size(), rd_cnt);
    end
    // Back in IDLE: a fresh write frame must be decoded immediately.
    send_byte(8'hAA, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h55, 1'b0);
    n_checks++;
    if (RF_WrEn !== 1'b1 || RF_Address !== 4'd7 || RF_WrData !== 8'h55) begin
      n_fail++;
      $display("FAIL rd_back_idle: got en=%b addr=%0d data=%02h, want en=1 addr=7 data=55", RF_WrEn, RF_Address, RF_WrData);
    end
  endtask

  task automatic test_alu_operands();
    clear_logs();
    send_byte(8'hCC, 1'b0);
    send_byte(8'h12, 1'b0);
    n_checks++;
    if (RF_WrEn !== 1'b1 || RF_Address !== 4'd0 || RF_WrData !== 8'h12 || CLK_GATE_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_opa: got en=%b addr=%0d data=%02h gate=%b, want 1 0 12 0", RF_WrEn, RF_Address, RF_WrData, CLK_GATE_EN);
    end
    send_byte(8'h34, 1'b0);
    n_checks++;
    if (RF_WrEn !== 1'b1 || RF_Address !== 4'd1 || RF_WrData !== 8'h34 || CLK_GATE_EN !== 1'b1 || ALU_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_opb: got en=%b addr=%0d data=%02h gate=%b alu_en=%b, want 1 1 34 1 0", RF_WrEn, RF_Address, RF_WrData, CLK_GATE_EN, ALU_EN);
    end
    send_byte(8'h00, 1'b0);
    n_checks++;
    if (ALU_EN !== 1'b1 || ALU_FUN !== 4'd0 || CLK_GATE_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_en: got en=%b fun=%0d gate=%b, want 1 0 1", ALU_EN, ALU_FUN, CLK_GATE_EN);
    end
    idle(3);
    n_checks++;
    if (CLK_GATE_EN !== 1'b1 || ALU_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_wait: got gate=%b en=%b, want gate=1 en=0", CLK_GATE_EN, ALU_EN);
    end
    ALU_OUT = 16'h0046;
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    ALU_OUT = 16'h0000;
    n_checks++;
    if (CLK_GATE_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_gate_off: got gate=%b, want 0", CLK_GATE_EN);
    end
    @(negedge CLK);
    n_checks++;
    if (TX_VLD !== 1'b1 || TX_DATA !== 8'h46) begin
      n_fail++;
      $display("FAIL alu_tx_lo: got vld=%b data=%02h, want vld=1 data=46", TX_VLD, TX_DATA);
    end
    idle(5);
    n_checks++;
    if (tx_log.size() != 2 || tx_log[0] !== 8'h46 || tx_log[1] !== 8'h00 || wr_log.size() != 2) begin
      n_fail++;
      $display("FAIL alu_resp: got tx=%0d writes=%0d, want tx=2 [46,00] writes=2", tx_log.size(), wr_log.size());
    end
    n_checks++;
    if (bad_gate != 0 || alu_cnt != 1) begin
      n_fail++;
      $display("FAIL alu_gate_order: got bad=%0d ops=%0d, want bad=0 ops=1", bad_gate, alu_cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    TX_FULL = 1'b1;
    send_byte(8'hDD, 1'b0);
    n_checks++;
    if (CLK_GATE_EN !== 1'b1 || ALU_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_gate: got gate=%b en=%b, want gate=1 en=0", CLK_GATE_EN, ALU_EN);
    end
    send_byte(8'h03, 1'b0);
    n_checks++;
    if (ALU_EN !== 1'b1 || ALU_FUN !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_alu_en: got en=%b fun=%0d, want en=1 fun=3", ALU_EN, ALU_FUN);
    end
    idle(2);
    ALU_OUT = 16'hBEEF;
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    ALU_OUT = 16'h0000;
    idle(10);
    n_checks++;
    if (tx_log.size() != 0 || ALU_FUN !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_hold: got tx=%0d fun=%0d, want tx=0 fun=3", tx_log.size(), ALU_FUN);
    end
    TX_FULL = 1'b0;
    idle(6);
    n_checks++;
    if (tx_log.size() != 2 || tx_log[0] !== 8'hEF || tx_log[1] !== 8'hBE) begin
      n_fail++;
      $display("FAIL bp_release: got tx=%0d, want tx=2 [ef,be]", tx_log.size());
    end
  endtask

  task automatic test_error_abort();
    clear_logs();
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    send_err();
    send_byte(8'h3C, 1'b0);
    idle(4);
    n_checks++;
    if (wr_log.size() != 0) begin
      n_fail++;
      $display("FAIL err_abort: got writes=%0d, want 0", wr_log.size());
    end
    send_byte(8'hAA, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h11, 1'b0);
    n_checks++;
    if (RF_WrEn !== 1'b1 || RF_Address !== 4'd6 || RF_WrData !== 8'h11) begin
      n_fail++;
      $display("FAIL err_recover: got en=%b addr=%0d data=%02h, want en=1 addr=6 data=11", RF_WrEn, RF_Address, RF_WrData);
    end
  endtask

  task automatic test_edge_cases();
    // Unknown opcode then a write frame; 0x7E must not shift the frame.
    clear_logs();
    send_byte(8'h7E, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h22, 1'b0);
    n_checks++;
    if (RF_WrEn !== 1'b1 || RF_Address !== 4'd8 || RF_WrData !== 8'h22) begin
      n_fail++;
      $display("FAIL unknown_op: got en=%b addr=%0d data=%02h, want en=1 addr=8 data=22", RF_WrEn, RF_Address, RF_WrData);
    end

    // Opcode carried with an error is dropped, so the following bytes are junk.
    clear_logs();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h09, 1'b0);
    send_byte(8'h44, 1'b0);
    idle(3);
    n_checks++;
    if (wr_log.size() != 0) begin
      n_fail++;
      $display("FAIL vld_err_same: got writes=%0d, want 0", wr_log.size());
    end

    // Stray result pulses in IDLE.
    clear_logs();
    RF_RdData_VLD = 1'b1;
    ALU_OUT_VLD = 1'b1;
    ALU_OUT = 16'h1234;
    @(negedge CLK);
    RF_RdData_VLD = 1'b0;
    ALU_OUT_VLD = 1'b0;
    idle(5);
    n_checks++;
    if (tx_log.size() != 0) begin
      n_fail++;
      $display("FAIL stray_vld: got tx=%0d, want 0", tx_log.size());
    end

    // Asynchronous reset while the ALU command is in flight.
    clear_logs();
    send_byte(8'hDD, 1'b0);
    send_byte(8'h05, 1'b0);
    #1;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_VLD} !== 5'b0 || ALU_FUN !== 4'd0 || RF_Address !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst: got strobes=%b fun=%0d addr=%0d, want 00000 0 0",
               {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_VLD}, ALU_FUN, RF_Address);
    end
    idle(2);
    RST = 1'b0;
    idle(1);
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    ALU_OUT = 16'h0000;
    idle(5);
    n_checks++;
    if (tx_log.size() != 0 || CLK_GATE_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: got tx=%0d gate=%b, want tx=0 gate=0", tx_log.size(), CLK_GATE_EN);
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_reg_read();
    test_alu_operands();
    test_backpressure();
    test_error_abort();
    test_edge_cases();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
